decoder_scan_seq: RTL

Sequencer that sits directly upstream of the 4-to-16 decoder and drives its 4-bit select input. It steps through channels 0..15 in order, skips masked channels, and holds each selected channel for a programmable dwell time. It inserts one dead cycle with `sel_en` low between channels, so the decoder outputs are break-before-make. It supports single-pass and continuous (wrapping) scans with start/stop control.

---
 rtl/decoder_scan_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq
// Channel scan sequencer feeding the select input of a 4-to-16 decoder.
// It steps through channels 0..15, skips masked channels and holds each
// enabled channel for dwell+1 cycles. A dead cycle with sel_en low separates
// channels, so the decoder outputs are break-before-make.
//
// State table
//   state   | meaning
//   IDLE    | waiting for start; decoder disabled
//   SEEK    | examining channel idx; decoder disabled
//   DWELL   | holding channel idx; decoder enabled, cnt counts down to 0
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a scan (accepted in IDLE only)
//   stop       in   abort the scan; wins over start
//   cont       in   1 = continuous (wrapping) scan, 0 = single pass
//   dwell      in   hold time per channel is dwell+1 cycles
//   skip_mask  in   bit i = 1 skips channel i
//   sel        out  channel code to the decoder
//   sel_en     out  decoder enable
//   busy       out  scan in progress
//   done       out  one-cycle pulse at the end of a single pass
//   wrap       out  one-cycle pulse on each 15 -> 0 wrap
module decoder_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        skip_mask,
  output logic [3:0]         sel,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEEK  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  logic [1:0]         state;
  logic [3:0]         idx;
  logic [DWELL_W-1:0] cnt;
  logic [15:0]        mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               cont_q;
  logic               done_p;
  logic               wrap_p;

  // Outputs are registered copies of the state seen one cycle earlier, so
  // done/wrap go through a one-cycle pending flag to stay aligned with the
  // IDLE / SEEK cycle they belong to. Stop bypasses this and clears the
  // outputs on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= 4'd0;
      cnt     <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      done_p  <= 1'b0;
      wrap_p  <= 1'b0;
      sel     <= 4'd0;
      sel_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      done_p <= 1'b0;
      wrap_p <= 1'b0;
      sel    <= (state == S_IDLE) ? 4'd0 : idx;
      sel_en <= (state == S_DWELL);
      busy   <= (state != S_IDLE);
      done   <= done_p;
      wrap   <= wrap_p;

      if (stop && state != S_IDLE) begin
        state  <= S_IDLE;
        idx    <= 4'd0;
        cnt    <= '0;
        sel    <= 4'd0;
        sel_en <= 1'b0;
        busy   <= 1'b0;
        wrap   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              mask_q  <= skip_mask;
              dwell_q <= dwell;
              cont_q  <= cont;
              idx     <= 4'd0;
              // nothing to scan: finish without ever leaving IDLE
              if (&skip_mask) done_p <= 1'b1;
              else            state  <= S_SEEK;
            end
          end
          S_SEEK: begin
            if (!mask_q[idx]) begin
              cnt   <= dwell_q;
              state <= S_DWELL;
            end else if (idx != 4'd15) begin
              idx <= idx + 4'd1;
            end else if (cont_q) begin
              idx    <= 4'd0;
              wrap_p <= 1'b1;
            end else begin
              idx    <= 4'd0;
              state  <= S_IDLE;
              done_p <= 1'b1;
            end
          end
          S_DWELL: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else if (idx != 4'd15) begin
              idx   <= idx + 4'd1;
              state <= S_SEEK;
            end else if (cont_q) begin
              idx    <= 4'd0;
              state  <= S_SEEK;
              wrap_p <= 1'b1;
            end else begin
              idx    <= 4'd0;
              state  <= S_IDLE;
              done_p <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            idx   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
